// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with shadowed display data,
// PWM brightness per digit slot, leading-zero blanking and frame pulse.
// Outputs registered, one cycle behind the scan counters; no backpressure.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   en_i              - scan enable; low turns every digit off
//   wr_i              - one-cycle strobe loading wdata_i/dp_i into the shadow
//   wdata_i, dp_i     - nibble and decimal point per digit (digit 0 in LSBs)
//   blank_lz_i        - leading-zero blanking enable (live)
//   bright_i          - brightness level, 0 dimmest .. all-ones full (live)
//   seg_o, dp_o, an_o - active-low segments {g..a}, decimal point, anodes
//   frame_o           - one-cycle pulse at each frame boundary
//   pending_o         - shadow holds data not yet shown
//
// Build option: define SEVENSEG_HEX_EN to show nibbles 10..15 as A b C d E F;
// otherwise those nibbles show a dash.

module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 100000,
   parameter int BRIGHT_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic                    wr_i,
   input  logic [4*NUM_DIGITS-1:0] wdata_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    blank_lz_i,
   input  logic [BRIGHT_W-1:0]     bright_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o,
   output logic                    pending_o
);

   localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   // Wide enough for (2^BRIGHT_W) * (CLK_DIV-1) with CLK_DIV up to 32 bits.
   localparam int PW = BRIGHT_W + 33;

   localparam logic [SW-1:0] SLOT_MAX = SW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIG_MAX  = DW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] DIV_M1   = PW'(CLK_DIV - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                  state_q;
   logic [SW-1:0]           slot_q;
   logic [DW-1:0]           digit_q;
   logic [4*NUM_DIGITS-1:0] shadow_dat_q;
   logic [NUM_DIGITS-1:0]   shadow_dp_q;
   logic [4*NUM_DIGITS-1:0] active_dat_q;
   logic [NUM_DIGITS-1:0]   active_dp_q;
   logic                    pending_q;
   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    frame_q;

   logic [3:0]              nib_arr_d [NUM_DIGITS];
   logic [DW-1:0]           hi_nz_d;
   logic [PW-1:0]           on_cnt_d;
   logic [3:0]              nib_d;
   logic                    blank_d;
   logic                    lit_d;
   logic                    frame_edge_d;
   logic                    xfer_d;
   logic [6:0]              seg_dec_d;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
`ifdef SEVENSEG_HEX_EN
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b1000110;
         4'hD:    return 7'b0100001;
         4'hE:    return 7'b0000110;
         default: return 7'b0001110;
`else
         default: return 7'b0111111;
`endif
      endcase
   endfunction

   always_comb begin
      hi_nz_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         nib_arr_d[k] = active_dat_q[4*k +: 4];
         if (active_dat_q[4*k +: 4] != 4'h0) hi_nz_d = DW'(k);
      end
      on_cnt_d  = ((PW'(bright_i) + PW'(1)) * DIV_M1) >> BRIGHT_W;
      nib_d     = nib_arr_d[digit_q];
      seg_dec_d = decode(nib_d);
      // Digit 0 can never exceed hi_nz_d, so it is never blanked.
      blank_d   = blank_lz_i && (digit_q > hi_nz_d) && !active_dp_q[digit_q];
      // Slot 0 is dead time so the previous digit's pattern cannot ghost.
      lit_d     = (state_q == SCAN) && en_i && (slot_q != '0) &&
                  (PW'(slot_q) <= on_cnt_d) && !blank_d;
      frame_edge_d = (state_q == SCAN) && en_i &&
                     (slot_q == SLOT_MAX) && (digit_q == DIG_MAX);
      // Active takes the shadow's old contents; a write in the same cycle
      // stays pending for the next boundary.
      xfer_d = ((state_q == IDLE) && en_i) || (frame_edge_d && pending_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         digit_q      <= '0;
         shadow_dat_q <= '0;
         shadow_dp_q  <= '0;
         active_dat_q <= '0;
         active_dp_q  <= '0;
         pending_q    <= 1'b0;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_q      <= 1'b0;
      end else begin
         if (wr_i) begin
            shadow_dat_q <= wdata_i;
            shadow_dp_q  <= dp_i;
         end
         if (xfer_d) begin
            active_dat_q <= shadow_dat_q;
            active_dp_q  <= shadow_dp_q;
         end
         pending_q <= wr_i || (pending_q && !xfer_d);

         frame_q <= frame_edge_d;
         an_q    <= lit_d ? ~(NUM_DIGITS'(1) << digit_q) : '1;
         seg_q   <= lit_d ? seg_dec_d : 7'h7F;
         dp_q    <= lit_d ? ~active_dp_q[digit_q] : 1'b1;

         case (state_q)
            IDLE: begin
               slot_q  <= '0;
               digit_q <= '0;
               if (en_i) state_q <= SCAN;
            end
            SCAN: begin
               if (!en_i) begin
                  state_q <= IDLE;
                  slot_q  <= '0;
                  digit_q <= '0;
               end else if (slot_q == SLOT_MAX) begin
                  slot_q  <= '0;
                  digit_q <= (digit_q == DIG_MAX) ? '0 : digit_q + 1'b1;
               end else begin
                  slot_q <= slot_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign seg_o     = seg_q;
   assign dp_o      = dp_q;
   assign an_o      = an_q;
   assign frame_o   = frame_q;
   assign pending_o = pending_q;

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits; legal range 1..16.
REQ-002 SHALL have parameter CLK_DIV, default 100000, clock cycles per digit slot; legal range >= 4.
REQ-003 SHALL have parameter BRIGHT_W, default 4, width of the brightness control.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en_i  input  1  scan enable; low forces all digits off.
REQ-007 wr_i  input  1  one-cycle strobe that loads wdata_i/dp_i into the shadow register.
REQ-008 wdata_i  input  4*NUM_DIGITS  nibble per digit; digit k is bits [4k+3:4k]; digit 0 is least significant.
REQ-009 dp_i  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 blank_lz_i  input  1  leading-zero blanking enable.
REQ-011 bright_i  input  BRIGHT_W  brightness level; 0 = dimmest, all-ones = full.
REQ-012 seg_o  output  7  {g,f,e,d,c,b,a}, active low.
REQ-013 dp_o  output  1  decimal point, active low.
REQ-014 an_o  output  NUM_DIGITS  digit anodes, active low, at most one bit low at a time.
REQ-015 frame_o  output  1  one-cycle pulse at each frame boundary.
REQ-016 pending_o  output  1  shadow holds data not yet applied.

Function
REQ-017 SHALL implement two states: IDLE (en_i low) and SCAN (en_i high). IDLE->SCAN on en_i high; SCAN->IDLE on en_i low, effective the next edge.
REQ-018 IDLE->SCAN SHALL copy shadow to active, clear pending, and set slot_cnt=0, digit_idx=0.
REQ-019 In SCAN, slot_cnt SHALL count 0..CLK_DIV-1 and wrap. At wrap, digit_idx SHALL increment modulo NUM_DIGITS.
REQ-020 A wrap of digit_idx from NUM_DIGITS-1 to 0 is the frame boundary. At the boundary, frame_o SHALL pulse for 1 cycle and active SHALL load shadow if pending, then clear pending.
REQ-021 wr_i SHALL always write the shadow and set pending; last write wins.
REQ-022 If wr_i coincides with a frame boundary, active SHALL take the old shadow, the new data SHALL remain pending, and it SHALL be applied at the next boundary.
REQ-023 on_cnt SHALL be ((bright_i+1)*(CLK_DIV-1)) >> BRIGHT_W, computed at full precision without overflow.
REQ-024 The an_o bit for digit_idx SHALL be low only while 1 <= slot_cnt <= on_cnt; slot_cnt 0 is dead time for anti-ghosting.
REQ-025 Outputs SHALL be registered and lag the counter state by exactly one cycle.
REQ-026 Leading-zero blanking: when blank_lz_i=1, every digit above the highest nonzero digit SHALL be blanked (an_o high, dp_o high). Digit 0 SHALL never be blanked. A digit with dp set is not blanked.
REQ-027 Decode 0..9: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-028 While no anode is active, seg_o SHALL be 1111111 and dp_o SHALL be 1.
REQ-029 bright_i and blank_lz_i SHALL be sampled live, not shadowed.

Reset
REQ-030 rst SHALL force IDLE, slot_cnt=0, digit_idx=0, shadow=0, active=0, pending_o=0, frame_o=0, an_o=all ones, seg_o=1111111, dp_o=1.
REQ-031 rst asserted mid-frame SHALL take effect at the next edge regardless of en_i or wr_i.

Configuration
REQ-032 Macro SEVENSEG_HEX_EN: when defined, nibbles 10..15 SHALL decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-033 Without SEVENSEG_HEX_EN, nibbles 10..15 SHALL decode to dash 0111111.

Verification (NUM_DIGITS=4, CLK_DIV=8, BRIGHT_W=2)
REQ-034 Stimulus: rst; wr 16'h1234; en=1; bright=3. Required: per 8-cycle slot, an_o=1110 for 7 cycles with seg_o=0011001, then 1101 with 0110000, 1011 with 0100100, 0111 with 1111001; frame_o pulses every 32 cycles.
REQ-035 Stimulus: bright=0. Required: each anode low for exactly 1 cycle per slot; bright=1 gives 3 cycles.
REQ-036 Stimulus: wr 16'h0042 with blank_lz=1. Required: digits 3 and 2 are never lit. Then set dp_i[3]=1: digit 3 is lit with seg_o=1000000 and dp_o=0.
REQ-037 Stimulus: mid-frame wr 16'hAAAA, then on the boundary cycle wr 16'h5555. Required: active=AAAA after the first boundary, 5555 after the next; pending_o drops accordingly.
REQ-038 Stimulus: wr 16'h00F0, both builds. Required: digit 1 shows 0001110 with SEVENSEG_HEX_EN and 0111111 without.
REQ-039 Stimulus: rst or en=0 mid-slot. Required: next edge all anodes high; on en re-assert, scan restarts at digit 0, slot_cnt 0.
